// File: rtl/sort_job_ctrl.sv
// Job sequencer around the quick-sort engine: loads a job into memory, runs the sorter, streams the result out.
// Optional macro SORT_CTRL_DESCEND_EN streams the sorted result out in descending order.
module sort_job_ctrl #(
  parameter int MM = 256,
  parameter int MN = 32,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MW:0]   job_num,
  input  logic          job_start,
  output logic          job_busy,
  output logic          job_done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MN-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MN-1:0] out_data,
  output logic          out_last,
  output logic [MW:0]   sort_num,
  output logic          sort_start,
  input  logic          sort_done,
  input  logic          sort_MemWr,
  input  logic [MW-1:0] sort_MemWrAddr,
  input  logic [MN-1:0] sort_MemWrData,
  input  logic          sort_MemRd,
  input  logic [MW-1:0] sort_MemRdAddr,
  output logic [MN-1:0] sort_MemRdData,
  output logic          MemWr,
  output logic [MW-1:0] MemWrAddr,
  output logic [MN-1:0] MemWrData,
  output logic          MemRd,
  output logic [MW-1:0] MemRdAddr,
  input  logic [MN-1:0] MemRdData
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SORT_START, SORT_WAIT, RD, RD_WAIT, OUT, DONE
  } state_t;

  localparam logic [MW:0]   CNT_ZERO  = {(MW+1){1'b0}};
  localparam logic [MW:0]   CNT_ONE   = {{MW{1'b0}}, 1'b1};
  localparam logic [MW:0]   CNT_TWO   = {{(MW-1){1'b0}}, 2'b10};
  localparam logic [MW:0]   CNT_MAX   = (MW+1)'(MM);
  localparam logic [MN-1:0] DATA_ZERO = {MN{1'b0}};
  localparam logic [MW-1:0] ADDR_ZERO = {MW{1'b0}};

  state_t        state_r, state_s;
  logic [MW:0]   n_r, n_s;
  logic [MW:0]   ld_cnt_r, ld_cnt_s;
  logic [MW:0]   rd_cnt_r, rd_cnt_s;
  logic [MW:0]   sort_num_r, sort_num_s;
  logic [MN-1:0] out_data_r, out_data_s;
  logic [MW:0]   job_len_s, n_last_s, rd_first_s, rd_step_s;
  logic          rd_last_s;

  // Clamp the requested length and derive the read-out walk (start, step, end).
  always_comb begin
    job_len_s = (job_num > CNT_MAX) ? CNT_MAX : job_num;
    n_last_s  = n_r - CNT_ONE;
`ifdef SORT_CTRL_DESCEND_EN
    rd_first_s = n_last_s;
    rd_step_s  = rd_cnt_r - CNT_ONE;
    rd_last_s  = (rd_cnt_r == CNT_ZERO);
`else
    rd_first_s = CNT_ZERO;
    rd_step_s  = rd_cnt_r + CNT_ONE;
    rd_last_s  = (rd_cnt_r == n_last_s);
`endif
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    ld_cnt_s   = ld_cnt_r;
    rd_cnt_s   = rd_cnt_r;
    sort_num_s = sort_num_r;
    out_data_s = out_data_r;
    case (state_r)
      IDLE: begin
        if (job_start) begin
          n_s      = job_len_s;
          ld_cnt_s = CNT_ZERO;
          state_s  = (job_len_s == CNT_ZERO) ? DONE : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          ld_cnt_s = ld_cnt_r + CNT_ONE;
          if (ld_cnt_r == n_last_s) begin
            rd_cnt_s = rd_first_s;
            if (n_r >= CNT_TWO) begin
              sort_num_s = n_r;
              state_s    = SORT_START;
            end else begin
              state_s = RD;
            end
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      SORT_START: state_s = SORT_WAIT;
      SORT_WAIT: begin
        if (sort_done) begin
          rd_cnt_s = rd_first_s;
          state_s  = RD;
        end else begin
          state_s = SORT_WAIT;
        end
      end
      RD:      state_s = RD_WAIT;
      RD_WAIT: begin
        out_data_s = MemRdData;
        state_s    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (rd_last_s) begin
            state_s = DONE;
          end else begin
            rd_cnt_s = rd_step_s;
            state_s  = RD;
          end
        end else begin
          state_s = OUT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      n_r        <= CNT_ZERO;
      ld_cnt_r   <= CNT_ZERO;
      rd_cnt_r   <= CNT_ZERO;
      sort_num_r <= CNT_ZERO;
      out_data_r <= DATA_ZERO;
    end else begin
      state_r    <= state_s;
      n_r        <= n_s;
      ld_cnt_r   <= ld_cnt_s;
      rd_cnt_r   <= rd_cnt_s;
      sort_num_r <= sort_num_s;
      out_data_r <= out_data_s;
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    job_busy       = (state_r != IDLE);
    job_done       = (state_r == DONE);
    in_ready       = (state_r == LOAD);
    out_valid      = (state_r == OUT);
    out_last       = (state_r == OUT) && rd_last_s;
    sort_start     = (state_r == SORT_START);
    sort_num       = sort_num_r;
    out_data       = out_data_r;
    sort_MemRdData = MemRdData;
  end

  // Memory port arbitration: the sorter owns the ports only while it runs.
  always_comb begin
    MemWr     = 1'b0;
    MemWrAddr = ADDR_ZERO;
    MemWrData = DATA_ZERO;
    MemRd     = 1'b0;
    MemRdAddr = ADDR_ZERO;
    case (state_r)
      SORT_START, SORT_WAIT: begin
        MemWr     = sort_MemWr;
        MemWrAddr = sort_MemWrAddr;
        MemWrData = sort_MemWrData;
        MemRd     = sort_MemRd;
        MemRdAddr = sort_MemRdAddr;
      end
      LOAD: begin
        MemWr     = in_valid;
        MemWrAddr = ld_cnt_r[MW-1:0];
        MemWrData = in_data;
      end
      RD: begin
        MemRd     = 1'b1;
        MemRdAddr = rd_cnt_r[MW-1:0];
      end
      default: begin
        MemWr = 1'b0;
        MemRd = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Self-checking bench for sort_job_ctrl: memory + sorter models, a job-level scoreboard and directed jobs.
module tb_sort_job_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  job_num;
  logic        job_start, job_busy, job_done;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [8:0]  sort_num;
  logic        sort_start, sort_done;
  logic        sort_MemWr, sort_MemRd;
  logic [7:0]  sort_MemWrAddr, sort_MemRdAddr;
  logic [31:0] sort_MemWrData, sort_MemRdData;
  logic        MemWr, MemRd;
  logic [7:0]  MemWrAddr, MemRdAddr;
  logic [31:0] MemWrData, MemRdData;

  logic [31:0] mem [0:255];
  logic [31:0] ld_q[$], exp_wr_q[$], exp_out_q[$], got_q[$];
  int          chk_cnt = 0, pass_cnt = 0;
  int          exp_n = 0, wr_idx = 0, ss_cnt = 0, done_cnt = 0, cyc = 0, done_cyc = 0;
  bit          sort_phase = 1'b0, hold_r = 1'b0;
  logic [31:0] hold_data;
  logic [31:0] lit [5];

  sort_job_ctrl #(.MM(256), .MN(32), .MW(8)) dut (
    .clk(clk), .reset(reset), .job_num(job_num), .job_start(job_start),
    .job_busy(job_busy), .job_done(job_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sort_num(sort_num), .sort_start(sort_start), .sort_done(sort_done),
    .sort_MemWr(sort_MemWr), .sort_MemWrAddr(sort_MemWrAddr), .sort_MemWrData(sort_MemWrData),
    .sort_MemRd(sort_MemRd), .sort_MemRdAddr(sort_MemRdAddr), .sort_MemRdData(sort_MemRdData),
    .MemWr(MemWr), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
    .MemRd(MemRd), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: one write and one read port, read data valid the cycle after MemRd.
  always @(posedge clk) begin
    if (MemWr) mem[MemWrAddr] <= MemWrData;
    if (MemRd) MemRdData <= mem[MemRdAddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Garbage on the sorter request inputs while the sorter is not supposed to own memory.
  task automatic noise();
    sort_MemWr = 1'b1; sort_MemWrAddr = 8'h55; sort_MemWrData = 32'hDEAD_BEEF;
    sort_MemRd = 1'b1; sort_MemRdAddr = 8'hAA;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(job_busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sort_start"}, 32'(sort_start), 32'd0);
    chk({tag, "_job_done"}, 32'(job_done), 32'd0);
    chk({tag, "_sort_num"}, 32'(sort_num), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_memwr"}, 32'(MemWr), 32'd0);
  endtask

  // Behavioural sorter: reads N words through the controller, sorts them, writes them back, pulses done.
  task automatic sorter(input int n, input bit poke);
    logic [31:0] b [0:255];
    logic [31:0] t;
    int j;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        b[i-1] = sort_MemRdData;
      end
      sort_MemWr = 1'b0;
      sort_MemRd = (i < n);
      sort_MemRdAddr = 8'(i);
    end
    for (int a = 1; a < n; a++) begin
      t = b[a]; j = a;
      while (j > 0) begin
        if (b[j-1] > t) begin b[j] = b[j-1]; j--; end
        else break;
      end
      b[j] = t;
    end
    sort_MemRd = 1'b0;
    for (int i = 0; i < n; i++) begin
      sort_MemWr = 1'b1; sort_MemWrAddr = 8'(i); sort_MemWrData = b[i];
      @(negedge clk);
    end
    sort_MemWr = 1'b0;
    if (poke) begin job_num = 9'd3; job_start = 1'b1; end
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0; job_start = 1'b0;
    noise();
  endtask

  // Scoreboard: checks every write, read address, output beat and sort handover against job-level expectations.
  initial begin : compare
    int ea;
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        exp_wr_q.delete(); exp_out_q.delete(); sort_phase = 1'b0; hold_r = 1'b0;
      end else begin
        chk("rdata_pass", sort_MemRdData, MemRdData);
        if (hold_r) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, hold_data);
        end
        hold_r = out_valid && !out_ready;
        hold_data = out_data;
        if (sort_start) begin
          chk("sort_num", 32'(sort_num), 32'(exp_n));
          ss_cnt++;
          sort_phase = 1'b1;
        end
        if (sort_phase) begin
          chk("mir_wr", 32'(MemWr), 32'(sort_MemWr));
          chk("mir_wraddr", 32'(MemWrAddr), 32'(sort_MemWrAddr));
          chk("mir_wrdata", MemWrData, sort_MemWrData);
          chk("mir_rd", 32'(MemRd), 32'(sort_MemRd));
          chk("mir_rdaddr", 32'(MemRdAddr), 32'(sort_MemRdAddr));
          if (sort_done) sort_phase = 1'b0;
        end else begin
          if (MemWr) begin
            if (exp_wr_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
            else begin
              e = exp_wr_q.pop_front();
              chk("wr_addr", 32'(MemWrAddr), 32'(wr_idx));
              chk("wr_data", MemWrData, e);
              wr_idx++;
            end
          end
          if (MemRd) begin
`ifdef SORT_CTRL_DESCEND_EN
            ea = exp_n - 1 - got_q.size();
`else
            ea = got_q.size();
`endif
            chk("rd_addr", 32'(MemRdAddr), 32'(ea) & 32'hFF);
          end
          if (out_valid && !out_ready) chk("rd_during_stall", 32'(MemRd), 32'd0);
          if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
              e = exp_out_q.pop_front();
              chk("out_data", out_data, e);
              chk("out_last", 32'(out_last), (exp_out_q.size() == 0) ? 32'd1 : 32'd0);
              got_q.push_back(out_data);
            end
          end
        end
        if (job_done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  // Runs one job of ld_q; optional output stall at word stall_at, optional reset after abort_at load beats.
  task automatic run_job(input int n, input int stall_at, input int abort_at, input bit poke);
    int ne, i, guard, ss0, d0, t0, j;
    bit gap;
    logic [31:0] s [0:255];
    logic [31:0] t;
    ne = (n > 256) ? 256 : n;
    exp_wr_q.delete(); exp_out_q.delete(); got_q.delete();
    wr_idx = 0; exp_n = ne;
    for (int k = 0; k < ne; k++) begin exp_wr_q.push_back(ld_q[k]); s[k] = ld_q[k]; end
    for (int a = 1; a < ne; a++) begin
      t = s[a]; j = a;
      while (j > 0) begin
        if (s[j-1] > t) begin s[j] = s[j-1]; j--; end
        else break;
      end
      s[j] = t;
    end
    for (int k = 0; k < ne; k++) begin
`ifdef SORT_CTRL_DESCEND_EN
      exp_out_q.push_back(s[ne-1-k]);
`else
      exp_out_q.push_back(s[k]);
`endif
    end
    ss0 = ss_cnt; d0 = done_cnt;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h1234_5678;
    @(negedge clk); in_valid = 1'b0; job_num = n[8:0]; job_start = 1'b1; t0 = cyc;
    @(negedge clk); job_start = 1'b0;
    chk("busy_after_start", 32'(job_busy), 32'd1);
    i = 0; guard = 0; gap = 1'b1;
    while (i < ne && guard < 2000) begin
      if (i == abort_at) break;
      sort_done = (i == 3);
      if (i == 2 && gap) begin in_valid = 1'b0; gap = 1'b0; end
      else begin
        in_valid = 1'b1; in_data = ld_q[i];
        if (in_ready) i++;
      end
      @(negedge clk); guard++;
    end
    in_valid = 1'b0; sort_done = 1'b0;
    if (abort_at >= 0) begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("rst_mid_load");
      reset = 1'b0;
      return;
    end
    chk("load_beats", 32'(i), 32'(ne));
    if (ne >= 2) begin
      guard = 0;
      while (!sort_start && guard < 20) begin @(negedge clk); guard++; end
      chk("sort_start_seen", 32'(sort_start), 32'd1);
      if (sort_start) sorter(ne, poke);
    end
    out_ready = 1'b1;
    if (stall_at >= 0) begin
      guard = 0;
      while (got_q.size() < stall_at && guard < 200) begin @(negedge clk); guard++; end
      out_ready = 1'b0;
      repeat (10) @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 5000) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sort_starts", 32'(ss_cnt - ss0), (ne >= 2) ? 32'd1 : 32'd0);
    chk("out_count", 32'(got_q.size()), 32'(ne));
    chk("writes_left", 32'(exp_wr_q.size()), 32'd0);
    if (ne == 0) chk("zero_len_latency", 32'((done_cyc - t0 >= 1) && (done_cyc - t0 <= 2)), 32'd1);
    chk("idle_after_job", 32'(job_busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1; job_num = 9'd0; job_start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    out_ready = 1'b1; sort_done = 1'b0;
    noise();
    repeat (3) @(negedge clk);
    check_idle("rst_init");
    reset = 1'b0;

    ld_q = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
    run_job(5, -1, 2, 1'b0);
    @(negedge clk);
    check_idle("after_abort");

    ld_q = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
    run_job(5, -1, -1, 1'b0);
`ifdef SORT_CTRL_DESCEND_EN
    lit = '{32'd9, 32'd7, 32'd5, 32'd3, 32'd1};
`else
    lit = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
`endif
    for (int k = 0; k < 5; k++) chk("basic_literal", got_q[k], lit[k]);

    ld_q = '{32'd40, 32'd10, 32'd30, 32'd20, 32'd50};
    run_job(5, 2, -1, 1'b0);
`ifdef SORT_CTRL_DESCEND_EN
    lit = '{32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
`else
    lit = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
`endif
    for (int k = 0; k < 5; k++) chk("stall_literal", got_q[k], lit[k]);

    ld_q.delete();
    run_job(0, -1, -1, 1'b0);

    ld_q = '{32'd42};
    run_job(1, -1, -1, 1'b0);
    chk("single_literal", got_q[0], 32'd42);

    ld_q.delete();
    for (int k = 0; k < 256; k++) ld_q.push_back(32'(255 - k));
    run_job(256, -1, -1, 1'b1);
`ifdef SORT_CTRL_DESCEND_EN
    chk("full_first", got_q[0], 32'd255);
    chk("full_last", got_q[255], 32'd0);
`else
    chk("full_first", got_q[0], 32'd0);
    chk("full_last", got_q[255], 32'd255);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
